// File: rtl/dmem_responder_if.sv
// Data-port request/response bus between the core's M stage and the memory responder.
// Two independent valid/ready channels: one for requests, one for responses.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data memory responder with a programmable access delay.
// It performs the access on the edge that enters RESP and holds the result until the response handshake.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            srst_n,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_req_hs;
  logic          w_resp_hs;
  logic          w_access;
  logic          w_bad;
  logic [AW-1:0] w_idx;

  assign w_req_hs  = (r_state == IDLE) && bus.req_valid;
  assign w_resp_hs = (r_state == RESP) && bus.resp_ready;
  assign w_access  = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_idx     = r_addr[AW+1:2];
  assign w_bad     = (r_addr[1:0] != 2'b00) ||
                     ({2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS));

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Every request passes through WAIT, so response arrives LATENCY+1 edges after acceptance.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req_hs)  w_next = WAIT;
      WAIT:    if (w_access)  w_next = RESP;
      RESP:    if (w_resp_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (r_state == IDLE);
    bus.resp_valid = (r_state == RESP);
    bus.resp_rdata = r_rdata;
    bus.resp_err   = r_err;
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_cnt   <= 4'(LATENCY);
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_be    <= bus.req_be;
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_err   <= w_bad;
        r_rdata <= (w_bad || r_we) ? 32'd0 : r_mem[w_idx];
      end
    end
  end

  // Array is deliberately unreset; a reset forces IDLE so a pending store never reaches this write.
  always_ff @(posedge clk) begin
    if (w_access && r_we && !w_bad) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with LATENCY 2, 0 and 4 share clock and reset.
module tb_dmem_responder;
  logic clk;
  logic srst_n;

  logic [2:0]       req_valid, req_we, resp_ready;
  logic [2:0][31:0] req_addr, req_wdata;
  logic [2:0][3:0]  req_be;
  logic [2:0]       req_ready, resp_valid, resp_err;
  logic [2:0][31:0] resp_rdata;

  int n_checks = 0;
  int n_err    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    dmem_responder_if u_if ();
    assign u_if.req_valid  = req_valid[k];
    assign u_if.req_we     = req_we[k];
    assign u_if.req_addr   = req_addr[k];
    assign u_if.req_wdata  = req_wdata[k];
    assign u_if.req_be     = req_be[k];
    assign u_if.resp_ready = resp_ready[k];
    assign req_ready[k]    = u_if.req_ready;
    assign resp_valid[k]   = u_if.resp_valid;
    assign resp_rdata[k]   = u_if.resp_rdata;
    assign resp_err[k]     = u_if.resp_err;

    dmem_responder #(
      .DEPTH_WORDS(1024),
      .LATENCY    ((k == 0) ? 2 : ((k == 1) ? 0 : 4))
    ) u_dut (
      .clk   (clk),
      .srst_n(srst_n),
      .bus   (u_if)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Full transaction: accept, measure latency, check response, complete handshake.
  task automatic xact(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] erd, input logic eerr,
                      input int lat, input string tag);
    int n;
    chk({tag, "/req_ready"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    n = 0;
    while (!resp_valid[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "/latency"}, 32'(n), 32'(lat + 1));
    chk({tag, "/rdata"}, resp_rdata[d], erd);
    chk({tag, "/err"}, 32'(resp_err[d]), 32'(eerr));
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    chk({tag, "/valid_drop"}, 32'(resp_valid[d]), 32'd0);
  endtask

  initial begin
    srst_n = 1'b0;
    req_valid = '0; req_we = '0; resp_ready = '0;
    req_addr = '0; req_wdata = '0; req_be = '0;

    // Reset values, before and across clock edges
    #1;
    chk("rst/req_ready", 32'(req_ready[0]), 32'd1);
    chk("rst/resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("rst/rdata", resp_rdata[0], 32'd0);
    chk("rst/err", 32'(resp_err[0]), 32'd0);
    req_valid = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    chk("rst_hold/req_ready", 32'(req_ready), 32'h7);
    chk("rst_hold/resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_hold/rdata", resp_rdata[0], 32'd0);
    srst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle/resp_valid", 32'(resp_valid), 32'h0);

    // LATENCY=2: store/load, merge, be=0, errors
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 2, "st10");
    xact(0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 2, "ld10");
    xact(0, 1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h0, 1'b0, 2, "st20a");
    xact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 2, "st20b");
    xact(0, 1'b0, 32'h20, 32'h0, 4'b1111, 32'h11BB33DD, 1'b0, 2, "ld20");
    xact(0, 1'b1, 32'h10, 32'h0, 4'b0000, 32'h0, 1'b0, 2, "st10_be0");
    xact(0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 2, "ld10_be0");
    xact(0, 1'b0, 32'h22, 32'h0, 4'b1111, 32'h0, 1'b1, 2, "ld22_misal");
    xact(0, 1'b1, 32'h0, 32'h01020304, 4'b1111, 32'h0, 1'b0, 2, "st0");
    xact(0, 1'b1, 32'hFFC, 32'h12345678, 4'b1111, 32'h0, 1'b0, 2, "stffc");
    xact(0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b1, 2, "st1000_oor");
    xact(0, 1'b0, 32'hFFC, 32'h0, 4'b0000, 32'h12345678, 1'b0, 2, "ldffc");
    xact(0, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h01020304, 1'b0, 2, "ld0_noalias");

    // LATENCY=0: backpressure with a competing store held on req_valid
    xact(1, 1'b1, 32'h8, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0, 0, "bp_st");
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h8;
    @(posedge clk); #1;
    req_we[1] = 1'b1; req_wdata[1] = 32'hFFFFFFFF; req_be[1] = 4'b1111;
    @(posedge clk); #1;
    chk("bp/valid", 32'(resp_valid[1]), 32'd1);
    chk("bp/rdata", resp_rdata[1], 32'h0BADF00D);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_hold/valid", 32'(resp_valid[1]), 32'd1);
      chk("bp_hold/rdata", resp_rdata[1], 32'h0BADF00D);
      chk("bp_hold/req_ready", 32'(req_ready[1]), 32'd0);
    end
    req_valid[1] = 1'b0; resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    resp_ready[1] = 1'b0;
    chk("bp_rel/valid", 32'(resp_valid[1]), 32'd0);
    chk("bp_rel/req_ready", 32'(req_ready[1]), 32'd1);
    xact(1, 1'b0, 32'h8, 32'h0, 4'b0000, 32'h0BADF00D, 1'b0, 0, "bp_ld");

    // LATENCY=4: reset during WAIT drops the pending store
    xact(2, 1'b1, 32'h40, 32'h77, 4'b1111, 32'h0, 1'b0, 4, "st40_old");
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h40;
    req_wdata[2] = 32'h55; req_be[2] = 4'b1111;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    chk("wait/req_ready", 32'(req_ready[2]), 32'd0);
    srst_n = 1'b0;
    #1;
    chk("rst_wait/req_ready", 32'(req_ready[2]), 32'd1);
    chk("rst_wait/resp_valid", 32'(resp_valid[2]), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    srst_n = 1'b1;
    @(posedge clk); #1;
    xact(2, 1'b0, 32'h40, 32'h0, 4'b0000, 32'h77, 1'b0, 4, "ld40_after_rst");

    // Reset while a response is being held clears outputs at once
    req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 32'h40;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("resp_hold/valid", 32'(resp_valid[2]), 32'd1);
    chk("resp_hold/rdata", resp_rdata[2], 32'h77);
    srst_n = 1'b0;
    #1;
    chk("rst_resp/valid", 32'(resp_valid[2]), 32'd0);
    chk("rst_resp/rdata", resp_rdata[2], 32'd0);
    chk("rst_resp/req_ready", 32'(req_ready[2]), 32'd1);
    @(posedge clk); #1;
    srst_n = 1'b1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
